// File: rtl/mult_final_add_pkg.sv
// Shared multiplier definitions: datapath width, CPA cut point and the
// sum/carry row pair handed from the reduction tree to the final adder.
package mult_final_add_pkg;

    localparam int MULT_W    = 16;
    localparam int CPA_SPLIT = 8;

    // Redundant-form result of the partial-product tree; both rows carry
    // bit i at weight 2^i.
    typedef struct packed {
        logic [MULT_W-1:0] sum;
        logic [MULT_W-1:0] carry;
    } sc_pair_t;

endpackage

// File: rtl/mult_final_add_cpa_slice.sv
// Purely combinational N-bit ripple-carry adder slice used by each
// pipeline stage of the final carry-propagate adder.
module cpa_slice #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] s,
    output logic         cout
);

    logic [N:0] c;

    // Ripple the carry through N full adders, LSB first.
    always_comb begin
        c[0] = cin;
        for (int i = 0; i < N; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        cout = c[N];
    end

endmodule

// File: rtl/mult_final_add.sv
// Two-stage pipelined carry-propagate adder closing the multiplier
// datapath. Stage 1 adds the low slice, stage 2 adds the high slice with
// the mid carry. Valid/ready on both sides, ready chains back without skid.
module mult_final_add
    import mult_final_add_pkg::*;
#(
    parameter int W     = MULT_W,
    parameter int SPLIT = CPA_SPLIT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] sum_vec,
    input  logic [W-1:0] carry_vec,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] product,
    output logic         cout
);

    localparam int HI_W = W - SPLIT;

    // Stage 1 state
    logic             s1_valid_q, s1_valid_d;
    logic [SPLIT-1:0] lo_q, lo_d;
    logic             c_mid_q, c_mid_d;
    logic [HI_W-1:0]  sum_hi_q, sum_hi_d;
    logic [HI_W-1:0]  carry_hi_q, carry_hi_d;

    // Stage 2 state
    logic             s2_valid_q, s2_valid_d;
    logic [W-1:0]     product_q, product_d;
    logic             cout_q, cout_d;

    // Adder results and handshake strobes
    logic [SPLIT-1:0] lo_sum;
    logic             lo_carry;
    logic [HI_W-1:0]  hi_sum;
    logic             hi_carry;
    logic             s1_load;
    logic             s2_load;

    cpa_slice #(.N(SPLIT)) u_cpa_lo (
        .a    (sum_vec[SPLIT-1:0]),
        .b    (carry_vec[SPLIT-1:0]),
        .cin  (1'b0),
        .s    (lo_sum),
        .cout (lo_carry)
    );

    cpa_slice #(.N(HI_W)) u_cpa_hi (
        .a    (sum_hi_q),
        .b    (carry_hi_q),
        .cin  (c_mid_q),
        .s    (hi_sum),
        .cout (hi_carry)
    );

    // Handshake: stage 2 takes stage 1 when it is empty or draining;
    // flush blocks new input for its cycle.
    always_comb begin
        s2_load  = s1_valid_q && (!s2_valid_q || out_ready);
        in_ready = !flush && (!s1_valid_q || s2_load);
        s1_load  = in_valid && in_ready;
    end

    // Next-state for valid bits and stage data; data holds unless loaded.
    always_comb begin
        // NOTE: every _d gets its hold value first so no path leaves it unassigned (no latches).
        s1_valid_d = s1_valid_q;
        lo_d       = lo_q;
        c_mid_d    = c_mid_q;
        sum_hi_d   = sum_hi_q;
        carry_hi_d = carry_hi_q;
        s2_valid_d = s2_valid_q;
        product_d  = product_q;
        cout_d     = cout_q;

        if (s1_load) begin
            lo_d       = lo_sum;
            c_mid_d    = lo_carry;
            sum_hi_d   = sum_vec[W-1:SPLIT];
            carry_hi_d = carry_vec[W-1:SPLIT];
        end

        if (s2_load && !flush) begin
            product_d = {hi_sum, lo_q};
            cout_d    = hi_carry;
        end

        if (flush) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
        end else begin
            if (s1_load)        s1_valid_d = 1'b1;
            else if (s2_load)   s1_valid_d = 1'b0;
            if (s2_load)        s2_valid_d = 1'b1;
            else if (out_ready) s2_valid_d = 1'b0;
        end
    end

    // Pipeline registers; everything returns to zero on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: data registers are reset too, because product/cout must read 0 out of reset.
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            lo_q       <= '0;
            c_mid_q    <= 1'b0;
            sum_hi_q   <= '0;
            carry_hi_q <= '0;
            s2_valid_q <= 1'b0;
            product_q  <= '0;
            cout_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            s1_valid_q <= s1_valid_d;
            lo_q       <= lo_d;
            c_mid_q    <= c_mid_d;
            sum_hi_q   <= sum_hi_d;
            carry_hi_q <= carry_hi_d;
            s2_valid_q <= s2_valid_d;
            product_q  <= product_d;
            cout_q     <= cout_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign product   = product_q;
    assign cout      = cout_q;

endmodule

// File: tb/tb_mult_final_add.sv
// Self-checking bench for mult_final_add: table vectors, random stream
// against an arithmetic model/scoreboard, and stall/flush/reset sequences.
module tb_mult_final_add;
    import mult_final_add_pkg::*;

    localparam int W = MULT_W;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] sum_vec = '0;
    logic [W-1:0] carry_vec = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] product;
    logic         cout;

    always #5 clk = ~clk;

    mult_final_add #(.W(W), .SPLIT(CPA_SPLIT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sum_vec   (sum_vec),
        .carry_vec (carry_vec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .cout      (cout)
    );

    typedef struct {
        sc_pair_t     pair;
        logic [W-1:0] exp_p;
        logic         exp_c;
    } vec_t;

    int total = 0;
    int bad   = 0;
    int n_acc = 0;
    int n_out = 0;
    int cyc   = 0;

    logic [W:0] exp_q[$];   // {cout, product} per accepted input, in order
    logic [W:0] cur_exp;    // expectation for whatever is on the input now

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: unsigned (W+1)-bit sum, top bit is the carry out.
    function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

    function automatic vec_t mk(input logic [W-1:0] s, input logic [W-1:0] c,
                                input logic [W-1:0] p, input logic co);
        vec_t v;
        v.pair.sum   = s;
        v.pair.carry = c;
        v.exp_p      = p;
        v.exp_c      = co;
        return v;
    endfunction

    // One clock: sample handshakes at negedge, score them, then step past posedge.
    task automatic cycle();
        logic [W:0] e;
        @(negedge clk);
        if (out_valid && out_ready) begin
            n_out++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_output: got 0x%0h expected no output", {cout, product});
            end else begin
                e = exp_q.pop_front();
                check("product", 32'(product), 32'(e[W-1:0]));
                check("cout", 32'(cout), 32'(e[W]));
            end
        end
        if (in_valid && in_ready) begin
            exp_q.push_back(cur_exp);
            n_acc++;
        end
        if (flush) exp_q.delete();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W:0] e);
        int acc0;
        acc0      = n_acc;
        in_valid  = 1'b1;
        sum_vec   = a;
        carry_vec = b;
        cur_exp   = e;
        for (int k = 0; k < 20 && n_acc == acc0; k++) cycle();
        if (n_acc == acc0) check("accept_timeout", n_acc, acc0 + 1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int k = 0; k < 20 && (exp_q.size() != 0 || out_valid); k++) cycle();
        check("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        vec_t         vecs[8];
        logic [W-1:0] a, b, held_p;
        int           o0, c0, acc0;

        vecs[0] = mk(16'h00FF, 16'h0001, 16'h0100, 1'b0);
        vecs[1] = mk(16'hFFFF, 16'h0001, 16'h0000, 1'b1);
        vecs[2] = mk(16'h8000, 16'h8000, 16'h0000, 1'b1);
        vecs[3] = mk(16'h0000, 16'h0000, 16'h0000, 1'b0);
        vecs[4] = mk(16'h1234, 16'h4321, 16'h5555, 1'b0);
        vecs[5] = mk(16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b1);
        vecs[6] = mk(16'h00FF, 16'hFF01, 16'h0000, 1'b1);
        vecs[7] = mk(16'h7F80, 16'h0080, 16'h8000, 1'b0);

        // Reset state
        #2;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_product", 32'(product), 0);
        check("rst_cout", 32'(cout), 0);
        cycle();
        cycle();
        rst_n = 1'b1;
        check("post_rst_in_ready", 32'(in_ready), 1);
        check("post_rst_out_valid", 32'(out_valid), 0);

        // Latency: first edge captures stage 1, second edge stage 2
        out_ready = 1'b1;
        in_valid  = 1'b1;
        sum_vec   = 16'h00FF;
        carry_vec = 16'h0001;
        cur_exp   = {1'b0, 16'h0100};
        cycle();
        in_valid = 1'b0;
        check("lat_edge1_out_valid", 32'(out_valid), 0);
        cycle();
        check("lat_edge2_out_valid", 32'(out_valid), 1);
        check("lat_product", 32'(product), 32'h0100);
        drain();

        // Table vectors, back to back
        o0 = n_out;
        for (int i = 0; i < 8; i++)
            send(vecs[i].pair.sum, vecs[i].pair.carry, {vecs[i].exp_c, vecs[i].exp_p});
        drain();
        check("table_count", n_out - o0, 8);

        // Backpressure: two accepts fill the pipe, then stall
        o0 = n_out;
        out_ready = 1'b0;
        send(16'd1, 16'd1, ref_add(16'd1, 16'd1));
        send(16'd2, 16'd2, ref_add(16'd2, 16'd2));
        in_valid  = 1'b1;
        sum_vec   = 16'd3;
        carry_vec = 16'd3;
        cur_exp   = ref_add(16'd3, 16'd3);
        check("bp_in_ready_low", 32'(in_ready), 0);
        check("bp_out_valid", 32'(out_valid), 1);
        held_p = product;
        acc0   = n_acc;
        for (int k = 0; k < 2; k++) begin
            cycle();
            check("bp_hold_product", 32'(product), 32'(held_p));
            check("bp_hold_valid", 32'(out_valid), 1);
            check("bp_in_ready_stall", 32'(in_ready), 0);
        end
        check("bp_no_accept", n_acc, acc0);
        out_ready = 1'b1;
        send(16'd3, 16'd3, ref_add(16'd3, 16'd3));
        send(16'd4, 16'd4, ref_add(16'd4, 16'd4));
        drain();
        check("bp_count", n_out - o0, 4);

        // Full-throughput random stream
        o0 = n_out;
        c0 = cyc;
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            a = W'($urandom);
            b = W'($urandom);
            send(a, b, ref_add(a, b));
        end
        check("throughput_cycles", cyc - c0, 100);
        drain();
        check("random_count", n_out - o0, 100);

        // Mid-operation reset with both stages full
        out_ready = 1'b0;
        send(16'h0101, 16'h0202, ref_add(16'h0101, 16'h0202));
        send(16'h0303, 16'h0404, ref_add(16'h0303, 16'h0404));
        check("mr_full_out_valid", 32'(out_valid), 1);
        rst_n = 1'b0;
        #1;
        check("mr_out_valid", 32'(out_valid), 0);
        check("mr_product", 32'(product), 0);
        check("mr_cout", 32'(cout), 0);
        exp_q.delete();
        cycle();
        rst_n = 1'b1;
        check("mr_in_ready", 32'(in_ready), 1);
        check("mr_out_valid_rel", 32'(out_valid), 0);
        o0 = n_out;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) cycle();
        check("mr_no_stale", n_out - o0, 0);

        // Flush with both stages full and consumer stalled
        out_ready = 1'b0;
        send(16'd10, 16'd10, ref_add(16'd10, 16'd10));
        send(16'd20, 16'd20, ref_add(16'd20, 16'd20));
        flush     = 1'b1;
        in_valid  = 1'b1;
        sum_vec   = 16'h0100;
        carry_vec = 16'h0001;
        cur_exp   = ref_add(16'h0100, 16'h0001);
        check("fl_in_ready", 32'(in_ready), 0);
        acc0 = n_acc;
        cycle();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("fl_out_valid", 32'(out_valid), 0);
        check("fl_no_accept", n_acc, acc0);
        o0 = n_out;
        send(16'h0A0A, 16'h0505, ref_add(16'h0A0A, 16'h0505));
        drain();
        check("fl_single_result", n_out - o0, 1);

        // Flush coinciding with out_ready: that cycle's transfer still counts
        out_ready = 1'b0;
        send(16'h1111, 16'h2222, ref_add(16'h1111, 16'h2222));
        send(16'h3333, 16'h4444, ref_add(16'h3333, 16'h4444));
        o0 = n_out;
        out_ready = 1'b1;
        flush     = 1'b1;
        cycle();
        flush = 1'b0;
        check("flr_out_valid", 32'(out_valid), 0);
        check("flr_xfer_count", n_out - o0, 1);
        for (int k = 0; k < 3; k++) cycle();
        check("flr_no_more", n_out - o0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
